// File: rtl/i281_pkg.sv
// Shared definitions for the i281 program-load path: loader FSM states,
// instruction word width and default code-memory sizing.
package i281_pkg;

    localparam int WORD_W         = 16;
    localparam int DEFAULT_ADDR_W = 6;
    localparam int DEFAULT_DEPTH  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } load_state_t;

    // Checksum contribution of one instruction: high byte XOR low byte.
    function automatic logic [7:0] byte_fold(input logic [WORD_W-1:0] w);
        return w[15:8] ^ w[7:0];
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Instruction stream into the loader and the code-memory write port out of it.
// The master drives the stream and observes writes; the slave is the loader.
// Backpressure is in_ready only; the write port cannot stall.
interface program_loader_if
    import i281_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) ();

    logic              in_valid;
    logic [WORD_W-1:0] in_word;
    logic              in_last;
    logic              in_ready;

    logic              cmem_we;
    logic [ADDR_W-1:0] cmem_addr;
    logic [WORD_W-1:0] cmem_data;

    modport master (
        output in_valid, in_word, in_last,
        input  in_ready, cmem_we, cmem_addr, cmem_data
    );

    modport slave (
        input  in_valid, in_word, in_last,
        output in_ready, cmem_we, cmem_addr, cmem_data
    );

endinterface

// File: rtl/load_addr_counter.sv
// Clearable, enabled up-counter giving the next write address and the word count.
// Latency: count updates on the clock edge after clr/en.
// Backpressure: none; clr has priority over en.
module load_addr_counter
    import i281_pkg::*;
#(
    parameter int W = DEFAULT_ADDR_W + 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a program word stream into code memory while holding the CPU, then releases it.
// Latency: one cycle from an accepted word to its cmem write pulse.
// Backpressure: in_ready is high only in LOAD; the memory write port never stalls.
module program_loader
    import i281_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    program_loader_if.slave   ld,
    output logic              cpu_hold,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic [7:0]        checksum
);

    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

    load_state_t       state_q;
    load_state_t       state_d;
    logic              in_ready_c;
    logic              cnt_clr;
    logic              cnt_en;
    logic              last_word;
    logic [ADDR_W:0]   count;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] data_q;
    logic [7:0]        csum_q;

    load_addr_counter #(
        .W (ADDR_W + 1)
    ) u_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        done       = 1'b0;
        cpu_hold   = 1'b1;
        cnt_clr    = 1'b0;
        // The word landing on the top address ends the load even without in_last.
        last_word  = ld.in_last || (count == LAST_ADDR);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_clr = 1'b1;
                end
            end
            LOAD: begin
                in_ready_c = 1'b1;
                if (ld.in_valid && last_word) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                done     = 1'b1;
                // Keep the CPU held while the final write is still in flight.
                cpu_hold = we_q;
                if (start) begin
                    state_d = LOAD;
                    cnt_clr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        cnt_en = ld.in_valid & in_ready_c;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            csum_q <= '0;
        end else begin
            we_q <= cnt_en;
            if (cnt_en) begin
                addr_q <= count[ADDR_W-1:0];
                data_q <= ld.in_word;
                csum_q <= csum_q ^ byte_fold(ld.in_word);
            end else if (cnt_clr) begin
                csum_q <= '0;
            end
        end
    end

    assign ld.in_ready  = in_ready_c;
    assign ld.cmem_we   = we_q;
    assign ld.cmem_addr = addr_q;
    assign ld.cmem_data = data_q;
    assign word_count   = count;
    assign checksum     = csum_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed scenarios plus a randomized phase, checked every cycle against a
// behavioural model of the load sequence, with literal pins on key results.
module tb_program_loader;
    import i281_pkg::*;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          cpu_hold;
    logic          done;
    logic [AW:0]   word_count;
    logic [7:0]    checksum;

    program_loader_if #(.ADDR_W(AW)) bus ();

    program_loader #(
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .ld         (bus.slave),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .word_count (word_count),
        .checksum   (checksum)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Model: which of the three phases we are in (0 idle, 1 load, 2 run),
    // words taken in this load, their folded XOR, and the write due this cycle.
    int          m_phase;
    int          m_count;
    logic [7:0]  m_csum;
    bit          m_we;
    int          m_addr;
    logic [15:0] m_data;
    int          n_writes;
    int          last_wr_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("in_ready", 32'(bus.in_ready), 32'(m_phase == 1));
        chk("done", 32'(done), 32'(m_phase == 2));
        chk("cpu_hold", 32'(cpu_hold), 32'(!(m_phase == 2 && !m_we)));
        chk("cmem_we", 32'(bus.cmem_we), 32'(m_we));
        if (m_we) begin
            chk("cmem_addr", 32'(bus.cmem_addr), 32'(m_addr));
            chk("cmem_data", 32'(bus.cmem_data), 32'(m_data));
        end
        chk("word_count", 32'(word_count), 32'(m_count));
        chk("checksum", 32'(checksum), 32'(m_csum));
        if (bus.cmem_we === 1'b1) begin
            n_writes++;
            last_wr_addr = int'(bus.cmem_addr);
        end
    endtask

    task automatic step(input bit s, input bit v, input logic [15:0] w, input bit l);
        bit acc;
        start        = s;
        bus.in_valid = v;
        bus.in_word  = w;
        bus.in_last  = l;
        acc  = (m_phase == 1) && v;
        m_we = acc;
        if (acc) begin
            m_addr = m_count;
            m_data = w;
        end
        case (m_phase)
            0, 2: if (s) begin
                m_phase = 1;
                m_count = 0;
                m_csum  = 8'h00;
            end
            default: if (acc) begin
                m_count++;
                m_csum = m_csum ^ w[15:8] ^ w[7:0];
                if (l || m_count == DEPTH) m_phase = 2;
            end
        endcase
        @(posedge clock);
        @(negedge clock);
        compare_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        #1;
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_cmem_we", 32'(bus.cmem_we), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cmem_addr", 32'(bus.cmem_addr), 32'd0);
        chk("rst_cmem_data", 32'(bus.cmem_data), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
        m_phase = 0;
        m_count = 0;
        m_csum  = 8'h00;
        m_we    = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        bus.in_word = 16'h0000;
        do_reset();
        idle_cycles(2);

        // Three-word load ending on in_last.
        n_writes = 0;
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 16'h8103, 1'b0);
        step(1'b0, 1'b1, 16'h9204, 1'b0);
        step(1'b0, 1'b1, 16'h0000, 1'b1);
        chk("l3_final_we", 32'(bus.cmem_we), 32'd1);
        chk("l3_final_addr", 32'(bus.cmem_addr), 32'd2);
        chk("l3_hold_during_write", 32'(cpu_hold), 32'd1);
        idle_cycles(1);
        chk("l3_hold_released", 32'(cpu_hold), 32'd0);
        chk("l3_done", 32'(done), 32'd1);
        chk("l3_word_count", 32'(word_count), 32'd3);
        chk("l3_checksum", 32'(checksum), 32'h14);
        chk("l3_writes", 32'(n_writes), 32'd3);

        // In RUN, stray in_valid is ignored.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'($urandom), 1'($urandom));
        chk("run_stray_count", 32'(word_count), 32'd3);

        // Reload from RUN with a single word.
        n_writes = 0;
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("reload_hold", 32'(cpu_hold), 32'd1);
        step(1'b0, 1'b1, 16'h1234, 1'b1);
        idle_cycles(2);
        chk("reload_count", 32'(word_count), 32'd1);
        chk("reload_checksum", 32'(checksum), 32'h26);
        chk("reload_addr", 32'(last_wr_addr), 32'd0);
        chk("reload_writes", 32'(n_writes), 32'd1);

        // IDLE: stray in_valid, then start with in_valid in the same cycle.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'($urandom), 1'b1);
        n_writes = 0;
        step(1'b1, 1'b1, 16'hBEEF, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("start_valid_no_accept", 32'(n_writes), 32'd0);
        chk("start_valid_count", 32'(word_count), 32'd0);

        // Gapped valid, with a start mid-load that must be ignored.
        step(1'b0, 1'b1, 16'h00A5, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b1, 16'h5A00, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("gap_writes", 32'(n_writes), 32'd2);
        chk("gap_last_addr", 32'(last_wr_addr), 32'd1);
        step(1'b0, 1'b1, 16'h0001, 1'b1);
        idle_cycles(2);

        // Overlong stream without in_last stops at DEPTH words.
        n_writes = 0;
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 70; i++) step(1'b0, 1'b1, 16'($urandom), 1'b0);
        chk("full_writes", 32'(n_writes), 32'd64);
        chk("full_last_addr", 32'(last_wr_addr), 32'd63);
        chk("full_count", 32'(word_count), 32'd64);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);

        // Reset after the fifth accepted word.
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'($urandom), 1'b0);
        chk("abort_we_before", 32'(bus.cmem_we), 32'd1);
        do_reset();
        idle_cycles(2);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                 16'($urandom), 1'($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
